// File: rtl/alu_regfile_datapath.sv
// alu_regfile_datapath: 32x32 register file with bypassed read ports feeding a registered ALU.
// Define ALU_OVF_EN to add the registered signed-overflow flag alu_ovf.
module alu_regfile_datapath #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [3:0]        alu_ctrl,
    input  logic [ADDR_W-1:0] src_reg1,
    input  logic [ADDR_W-1:0] src_reg2,
    input  logic [ADDR_W-1:0] dest_reg,
    input  logic              imm_sel,
    input  logic [DATA_W-1:0] imm,
`ifdef ALU_OVF_EN
    output logic              alu_ovf,
`endif
    output logic [DATA_W-1:0] alu_result,
    output logic              alu_zero,
    output logic [1:0]        cycle_cnt
);
    localparam int NREG = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] alu_result_q, alu_result_d, alu_out;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic              pend_vld_q, pend_vld_d;
    logic [1:0]        cycle_cnt_q, cycle_cnt_d;
    logic [DATA_W-1:0] rs1_val, rs2_val, op_a, op_b, sum, diff;
    logic              wb_en;

    assign wb_en = pend_vld_q && pend_addr_q != '0;
    // The pending result is not yet in the array, so matching reads take it straight from alu_result_q.
    assign rs1_val = (src_reg1 == '0) ? '0 : (wb_en && src_reg1 == pend_addr_q) ? alu_result_q : regs_q[src_reg1];
    assign rs2_val = (src_reg2 == '0) ? '0 : (wb_en && src_reg2 == pend_addr_q) ? alu_result_q : regs_q[src_reg2];
    assign op_a = rs1_val;
    assign op_b = imm_sel ? imm : rs2_val;
    assign sum  = op_a + op_b;
    assign diff = op_a - op_b;

    always_comb begin
        alu_out = '0;
        case (alu_ctrl)
            4'b0000: alu_out = op_a & op_b;
            4'b0001: alu_out = op_a | op_b;
            4'b0010: alu_out = sum;
            4'b0110: alu_out = diff;
            4'b0111: alu_out = {{(DATA_W-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            4'b1100: alu_out = ~(op_a | op_b);
            4'b0011: alu_out = op_a ^ op_b;
            4'b1111: alu_out = op_b;
            default: alu_out = '0;
        endcase
    end

    always_comb begin
        alu_result_d = en ? alu_out : alu_result_q;
        pend_addr_d  = en ? dest_reg : pend_addr_q;
        pend_vld_d   = en;
        cycle_cnt_d  = cycle_cnt_q + 2'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
            alu_result_q <= '0;
            pend_addr_q  <= '0;
            pend_vld_q   <= 1'b0;
            cycle_cnt_q  <= '0;
        end else begin
            if (wb_en) regs_q[pend_addr_q] <= alu_result_q;
            alu_result_q <= alu_result_d;
            pend_addr_q  <= pend_addr_d;
            pend_vld_q   <= pend_vld_d;
            cycle_cnt_q  <= cycle_cnt_d;
        end
    end

`ifdef ALU_OVF_EN
    logic ovf_q, ovf_d, ovf_c;
    assign ovf_c = (alu_ctrl == 4'b0010) ? (op_a[DATA_W-1] == op_b[DATA_W-1] && sum[DATA_W-1] != op_a[DATA_W-1]) :
                   (alu_ctrl == 4'b0110) ? (op_a[DATA_W-1] != op_b[DATA_W-1] && diff[DATA_W-1] != op_a[DATA_W-1]) : 1'b0;
    assign ovf_d = en ? ovf_c : ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf_q <= 1'b0;
        else        ovf_q <= ovf_d;
    end

    assign alu_ovf = ovf_q;
`endif

    assign alu_result = alu_result_q;
    assign alu_zero   = alu_out == '0;
    assign cycle_cnt  = cycle_cnt_q;
endmodule

// File: tb/tb_alu_regfile_datapath.sv
// tb_alu_regfile_datapath: directed-vector bench for alu_regfile_datapath.
// Exercises the alu_ovf flag as well when ALU_OVF_EN is defined.
module tb_alu_regfile_datapath;
    logic        clk = 1'b0, rst_n = 1'b0, en = 1'b0, imm_sel = 1'b0;
    logic [3:0]  alu_ctrl = 4'b0;
    logic [4:0]  src_reg1 = '0, src_reg2 = '0, dest_reg = '0;
    logic [31:0] imm = '0, alu_result;
    logic        alu_zero;
    logic [1:0]  cycle_cnt, tb_cnt = 2'd0;
    int          n_cmp = 0, n_err = 0;
`ifdef ALU_OVF_EN
    logic        alu_ovf;
`endif

    localparam logic [3:0] AND_ = 4'b0000, OR_ = 4'b0001, ADD = 4'b0010, SUB = 4'b0110,
                           SLT = 4'b0111, NOR_ = 4'b1100, XOR_ = 4'b0011, PASS = 4'b1111;

    alu_regfile_datapath dut (
        .clk(clk), .rst_n(rst_n), .en(en), .alu_ctrl(alu_ctrl),
        .src_reg1(src_reg1), .src_reg2(src_reg2), .dest_reg(dest_reg),
        .imm_sel(imm_sel), .imm(imm),
`ifdef ALU_OVF_EN
        .alu_ovf(alu_ovf),
`endif
        .alu_result(alu_result), .alu_zero(alu_zero), .cycle_cnt(cycle_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic op(input logic e, input logic [3:0] c, input logic [4:0] a, input logic [4:0] b,
                      input logic [4:0] d, input logic s, input logic [31:0] i);
        en = e; alu_ctrl = c; src_reg1 = a; src_reg2 = b; dest_reg = d; imm_sel = s; imm = i;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) tb_cnt = tb_cnt + 2'd1;
        #1;
    endtask

    initial begin
        #22 rst_n = 1'b1;
        chk("rst_result", alu_result, 0);
        chk("rst_cnt", {30'b0, cycle_cnt}, 0);
        op(1, PASS, 0, 5, 0, 0, 0);
        chk("rst_read_zero", {31'b0, alu_zero}, 1);
        tick();
        chk("rst_read_res", alu_result, 0);
        op(1, PASS, 0, 0, 1, 1, 5);      tick(); chk("pass5", alu_result, 5);
        op(1, PASS, 0, 0, 2, 1, 7);      tick(); chk("pass7", alu_result, 7);
        op(1, ADD, 1, 2, 3, 0, 0);
        chk("add_zero", {31'b0, alu_zero}, 0);
        tick();
        chk("add_bypass", alu_result, 12);
        chk("cnt_wrap", {30'b0, cycle_cnt}, {30'b0, tb_cnt});
        op(1, SUB, 1, 2, 4, 0, 0);       tick(); chk("sub", alu_result, 32'hFFFF_FFFE);
        op(1, SLT, 1, 2, 5, 0, 0);       tick(); chk("slt_lt", alu_result, 1);
        op(1, SLT, 2, 1, 6, 0, 0);
        chk("slt_ge_zero", {31'b0, alu_zero}, 1);
        tick();
        chk("slt_ge", alu_result, 0);
        op(1, SLT, 4, 1, 6, 0, 0);       tick(); chk("slt_neg", alu_result, 1);
        op(1, PASS, 0, 0, 0, 1, 9);      tick(); chk("pass_r0", alu_result, 9);
        op(1, PASS, 0, 0, 7, 0, 0);
        chk("r0_zero", {31'b0, alu_zero}, 1);
        tick();
        chk("r0_read", alu_result, 0);
        op(1, PASS, 0, 0, 8, 1, 32'hFFFF_FFFF); tick();
        op(1, ADD, 8, 0, 9, 1, 1);
        chk("wrap_zero", {31'b0, alu_zero}, 1);
        tick();
        chk("add_wrap", alu_result, 0);
        op(1, AND_, 3, 3, 10, 0, 0);     tick(); chk("and_same", alu_result, 12);
        op(1, OR_, 1, 0, 10, 1, 32'h30); tick(); chk("or", alu_result, 32'h35);
        op(1, XOR_, 1, 2, 10, 0, 0);     tick(); chk("xor", alu_result, 2);
        op(1, NOR_, 1, 0, 10, 1, 32'hFFFF_FFF0); tick(); chk("nor", alu_result, 32'hA);
        op(1, 4'b0101, 1, 2, 10, 0, 0);  tick(); chk("undef_op", alu_result, 0);
        op(1, PASS, 0, 0, 12, 1, 32'hAB); tick(); chk("pass_ab", alu_result, 32'hAB);
        op(0, PASS, 0, 0, 13, 1, 32'h55);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold", alu_result, 32'hAB);
            chk("cnt_run", {30'b0, cycle_cnt}, {30'b0, tb_cnt});
        end
        op(1, PASS, 0, 12, 11, 0, 0);    tick(); chk("r12_written", alu_result, 32'hAB);
        op(1, PASS, 0, 13, 11, 0, 0);    tick(); chk("r13_untouched", alu_result, 0);
        op(1, PASS, 0, 9, 11, 0, 0);     tick(); chk("r9_read", alu_result, 0);
`ifdef ALU_OVF_EN
        op(1, PASS, 0, 0, 15, 1, 32'h7FFF_FFFF); tick();
        chk("ovf_pass", {31'b0, alu_ovf}, 0);
        op(1, ADD, 15, 0, 16, 1, 1);     tick();
        chk("ovf_add_res", alu_result, 32'h8000_0000);
        chk("ovf_add", {31'b0, alu_ovf}, 1);
        op(1, SUB, 1, 2, 16, 0, 0);      tick(); chk("ovf_sub_none", {31'b0, alu_ovf}, 0);
`endif
        op(1, PASS, 0, 0, 14, 1, 32'h77); tick(); chk("pass77", alu_result, 32'h77);
        op(0, PASS, 0, 0, 0, 1, 0);
        #2 rst_n = 1'b0; tb_cnt = 2'd0;
        #1;
        chk("midrst_result", alu_result, 0);
        chk("midrst_cnt", {30'b0, cycle_cnt}, 0);
`ifdef ALU_OVF_EN
        chk("midrst_ovf", {31'b0, alu_ovf}, 0);
`endif
        tick();
        rst_n = 1'b1;
        op(1, PASS, 0, 14, 11, 0, 0);
        chk("r14_zero", {31'b0, alu_zero}, 1);
        tick();
        chk("r14_read", alu_result, 0);
        op(1, PASS, 0, 12, 11, 0, 0);    tick(); chk("r12_cleared", alu_result, 0);
        chk("cnt_after_rst", {30'b0, cycle_cnt}, {30'b0, tb_cnt});
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
